// File: rtl/noise_acq_sched_if.sv
// Host/front-end signal bundle for the noise-acquisition sequencer.
// Slave is the sequencer; master is the host plus the switch/ADC observer.
interface noise_acq_sched_if #(
  parameter int CW = 16
);
  logic          nload;
  logic [1:0]    naddr;
  logic [CW-1:0] ndatain;
  logic          noisestart;
  logic          nchoice;
  logic          intclr;
  logic          busy;
  logic          dumpon_ctr;
  logic          dumpoff_ctr;
  logic          rt_sw;
  logic          sw_acq1;
  logic          sw_acq2;
  logic          n_acq;
  logic          interrupt;

  modport slave (
    input  nload, naddr, ndatain, noisestart, nchoice, intclr,
    output busy, dumpon_ctr, dumpoff_ctr, rt_sw, sw_acq1, sw_acq2, n_acq, interrupt
  );

  modport master (
    output nload, naddr, ndatain, noisestart, nchoice, intclr,
    input  busy, dumpon_ctr, dumpoff_ctr, rt_sw, sw_acq1, sw_acq2, n_acq, interrupt
  );
endinterface

// File: rtl/noise_acq_sched.sv
// Noise-shot sequencer: dump, break-before-make gaps, receiver settle, timed sample strobes,
// then a sticky completion interrupt. Outputs are registered decodes of the next state.
module noise_acq_sched #(
  parameter int CW      = 16,
  parameter int GAP_CYC = 2
) (
  input  logic            clk_sys,
  input  logic            noiserst,
  noise_acq_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP_A, S_DUMP, S_GAP_B, S_SETTLE, S_ACQ, S_DONE
  } state_e;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] GAP = CW'(GAP_CYC);

  state_e                 state_q, state_d;
  logic [3:0][CW-1:0]     tmr_q, tmr_d;     // 0=T_DUMP 1=T_SETTLE 2=T_SAMPLE 3=N_ACQ
  logic [CW-1:0]          cnt_q, cnt_d;     // 1-based cycle index within the current phase
  logic [CW-1:0]          samp_q, samp_d;   // 1..T_SAMPLE within one sample period
  logic [CW-1:0]          acq_q, acq_d;     // 1..N_ACQ sample period index
  logic                   ch_q, ch_d;
  logic                   irq_q, irq_d;
  logic                   start_acc;
  logic                   busy_q, dumpon_q, dumpoff_q, rt_q, acq1_q, acq2_q, nacq_q;
  logic [CW-1:0]          dump_len, settle_len, samp_len;

  // Zero-valued timing words behave as a single cycle.
  assign dump_len   = (tmr_q[0] == '0) ? ONE : tmr_q[0];
  assign settle_len = (tmr_q[1] == '0) ? ONE : tmr_q[1];
  assign samp_len   = (tmr_q[2] == '0) ? ONE : tmr_q[2];

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q + ONE;
    samp_d    = samp_q;
    acq_d     = acq_q;
    ch_d      = ch_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = ONE;
        if (bus.nload) tmr_d[bus.naddr] = bus.ndatain;
        if (bus.noisestart) begin
          state_d   = S_GAP_A;
          ch_d      = bus.nchoice;
          start_acc = 1'b1;
        end
      end
      S_GAP_A: if (cnt_q == GAP) begin
        state_d = S_DUMP;
        cnt_d   = ONE;
      end
      S_DUMP: if (cnt_q == dump_len) begin
        state_d = S_GAP_B;
        cnt_d   = ONE;
      end
      S_GAP_B: if (cnt_q == GAP) begin
        state_d = S_SETTLE;
        cnt_d   = ONE;
      end
      S_SETTLE: if (cnt_q == settle_len) begin
        state_d = (tmr_q[3] == '0) ? S_DONE : S_ACQ;
        cnt_d   = ONE;
        samp_d  = ONE;
        acq_d   = ONE;
      end
      S_ACQ: begin
        if (samp_q == samp_len) begin
          if (acq_q == tmr_q[3]) begin
            state_d = S_DONE;
          end else begin
            samp_d = ONE;
            acq_d  = acq_q + ONE;
          end
        end else begin
          samp_d = samp_q + ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = ONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion set takes priority over any clear in the same cycle.
    if (state_d == S_DONE)              irq_d = 1'b1;
    else if (bus.intclr || start_acc)   irq_d = 1'b0;
    else                                irq_d = irq_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!noiserst) begin
      state_q   <= S_IDLE;
      tmr_q     <= {CW'(16), CW'(10), CW'(50), CW'(100)};
      cnt_q     <= ONE;
      samp_q    <= ONE;
      acq_q     <= ONE;
      ch_q      <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
      dumpon_q  <= 1'b0;
      dumpoff_q <= 1'b1;
      rt_q      <= 1'b0;
      acq1_q    <= 1'b0;
      acq2_q    <= 1'b0;
      nacq_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      acq_q     <= acq_d;
      ch_q      <= ch_d;
      irq_q     <= irq_d;
      busy_q    <= (state_d != S_IDLE);
      dumpon_q  <= (state_d == S_DUMP);
      dumpoff_q <= (state_d == S_IDLE) || (state_d == S_SETTLE) ||
                   (state_d == S_ACQ)  || (state_d == S_DONE);
      rt_q      <= (state_d == S_SETTLE) || (state_d == S_ACQ);
      acq1_q    <= (state_d == S_ACQ) && !ch_d;
      acq2_q    <= (state_d == S_ACQ) &&  ch_d;
      nacq_q    <= (state_d == S_ACQ) && (samp_d == samp_len);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.dumpon_ctr  = dumpon_q;
  assign bus.dumpoff_ctr = dumpoff_q;
  assign bus.rt_sw       = rt_q;
  assign bus.sw_acq1     = acq1_q;
  assign bus.sw_acq2     = acq2_q;
  assign bus.n_acq       = nacq_q;
  assign bus.interrupt   = irq_q;

endmodule
